// File: rtl/uart_pwm_rgb.sv
// UART (oversampled, glitch-rejecting) -> two-byte command parser -> CHANNELS glitch-free PWM outputs.
// cmd_valid one clock after the duty byte's stop sample; duty takes effect at the next PWM wrap.
module uart_pwm_rgb #(
  parameter int CLOCK_FREQ     = 12000000,
  parameter int BAUD           = 9600,
  parameter int OVERSAMPLE     = 16,
  parameter int CHANNELS       = 3,
  parameter int PWM_BITS       = 8,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                cmd_valid,
  output logic                cmd_err,
  output logic                frame_err
);

  localparam int DIV_RAW = CLOCK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = ~PWM_BITS'(1);
  localparam logic POL = (ACTIVE_LOW != 0);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic {P_IDLE, P_DUTY} p_state_t;

  logic                r_rx_meta, r_rx_sync;
  logic [DIV_W-1:0]    r_div_cnt;
  logic                w_tick;
  rx_state_t           r_rx_state, w_rx_next;
  logic [OS_W-1:0]     r_os_cnt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic                w_half, w_full, w_sample, w_byte_vld, w_frame_bad;
  p_state_t            r_p_state, w_p_next;
  logic [3:0]          r_ch;
  logic [TO_W-1:0]     r_to_cnt;
  logic                w_ch_ok, w_timeout, w_cmd_ok, w_cmd_bad;
  logic [PWM_BITS-1:0] w_duty;
  logic [PWM_BITS-1:0] r_shadow [CHANNELS];
  logic [PWM_BITS-1:0] r_active [CHANNELS];
  logic [PWM_BITS-1:0] r_cnt;
  logic                w_wrap;
  logic [CHANNELS-1:0] r_pwm;
  logic                r_cmd_valid, r_cmd_err, r_frame_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)      r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + DIV_W'(1);
  end

  assign w_half = (r_os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
  assign w_full = (r_os_cnt == OS_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_tick && !r_rx_sync) w_rx_next = RX_START;
      RX_START: if (w_tick && w_half) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && w_full && r_bit_cnt == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_tick && w_full) w_rx_next = r_rx_sync ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (w_tick && r_rx_sync) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_sample    = (r_rx_state == RX_DATA) && w_tick && w_full;
    w_byte_vld  = (r_rx_state == RX_STOP) && w_tick && w_full && r_rx_sync;
    w_frame_bad = (r_rx_state == RX_STOP) && w_tick && w_full && !r_rx_sync;
  end

  // Oversample counter restarts on every state change and after each full bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (w_tick) begin
        if (w_rx_next != r_rx_state || w_full ||
            r_rx_state == RX_IDLE || r_rx_state == RX_BREAK)
          r_os_cnt <= '0;
        else
          r_os_cnt <= r_os_cnt + OS_W'(1);
      end
      if (r_rx_state == RX_START) r_bit_cnt <= '0;
      else if (w_sample)          r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_sample) r_shift <= {r_rx_sync, r_shift[7:1]};
    end
  end

  assign w_ch_ok   = ({1'b0, r_ch} < 5'(CHANNELS));
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_duty    = PWM_BITS'(r_shift);

  always_ff @(posedge clk) begin
    if (!rst_n) r_p_state <= P_IDLE;
    else        r_p_state <= w_p_next;
  end

  always_comb begin
    w_p_next = r_p_state;
    case (r_p_state)
      P_IDLE:  if (w_byte_vld && r_shift[7:4] == 4'hC) w_p_next = P_DUTY;
      P_DUTY:  if (w_frame_bad || w_byte_vld || w_timeout) w_p_next = P_IDLE;
      default: w_p_next = P_IDLE;
    endcase
  end

  // A framing error while waiting for the duty byte drops the command silently.
  always_comb begin
    w_cmd_ok  = (r_p_state == P_DUTY) && w_byte_vld && w_ch_ok;
    w_cmd_bad = (r_p_state == P_DUTY) && !w_frame_bad &&
                ((w_byte_vld && !w_ch_ok) || (!w_byte_vld && w_timeout));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ch        <= '0;
      r_to_cnt    <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) r_shadow[i] <= '0;
    end else begin
      if (r_p_state == P_IDLE && w_p_next == P_DUTY) r_ch <= r_shift[3:0];
      if (r_p_state == P_IDLE) r_to_cnt <= '0;
      else                     r_to_cnt <= r_to_cnt + TO_W'(1);
      r_cmd_valid <= w_cmd_ok;
      r_cmd_err   <= w_cmd_bad;
      r_frame_err <= w_frame_bad;
      for (int i = 0; i < CHANNELS; i++)
        if (w_cmd_ok && r_ch == 4'(i)) r_shadow[i] <= w_duty;
    end
  end

  assign w_wrap = (r_cnt == CNT_MAX);

  // Active duty only changes at the wrap, so a period is never cut short or stretched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_pwm <= {CHANNELS{POL}};
      for (int i = 0; i < CHANNELS; i++) r_active[i] <= '0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + PWM_BITS'(1);
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_wrap) r_active[i] <= r_shadow[i];
        r_pwm[i] <= (r_cnt < r_active[i]) ^ POL;
      end
    end
  end

  assign pwm_out   = r_pwm;
  assign cmd_valid = r_cmd_valid;
  assign cmd_err   = r_cmd_err;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_pwm_rgb.sv
// Directed bench for uart_pwm_rgb: one bit = 16 clocks, PWM period 255 clocks, timeout 400 clocks.
module tb_uart_pwm_rgb;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [2:0] pwm_out;
  logic       cmd_valid, cmd_err, frame_err;

  uart_pwm_rgb #(
    .CLOCK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16), .CHANNELS(3),
    .PWM_BITS(8), .TIMEOUT_CYCLES(400), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .pwm_out(pwm_out),
    .cmd_valid(cmd_valid), .cmd_err(cmd_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0, n_fail = 0;
  int n_vld = 0, n_err = 0, n_ferr = 0, n_both = 0;
  int last_vld = -1, last_err = -1, last_ferr = -1;
  logic [2:0] hist [16384];

  always @(negedge clk) begin
    if (cyc < 16384) hist[cyc] = pwm_out;
    if (cmd_valid === 1'b1) begin n_vld++;  last_vld  = cyc; end
    if (cmd_err   === 1'b1) begin n_err++;  last_err  = cyc; end
    if (frame_err === 1'b1) begin n_ferr++; last_ferr = cyc; end
    if (cmd_valid === 1'b1 && cmd_err === 1'b1) n_both++;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  // Start driven right after edge N; stop sample lands at N+154, pulses visible at N+155.
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    rx = 1'b0; idle(16);
    for (int i = 0; i < 8; i++) begin rx = b[i]; idle(16); end
    if (stop_low > 0) begin rx = 1'b0; idle(stop_low); end
    rx = 1'b1; idle(16);
  endtask

  function automatic int lows(input int ch, input int from);
    int n = 0;
    for (int c = from; c < from + 255; c++)
      if (c >= 0 && c < 16384 && hist[c][ch] === 1'b0) n++;
    return n;
  endfunction

  int r0, n, e0, s, w;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    idle(5);
    check_val("rst_pwm", int'(pwm_out), 7);
    check_val("rst_pulses", int'({cmd_valid, cmd_err, frame_err}), 0);
    rst_n = 1'b1;
    r0 = cyc;
    idle(300);
    check_val("idle_pulses", n_vld + n_err + n_ferr, 0);
    check_val("idle_pwm_ch1", lows(1, cyc - 256), 0);

    n = cyc;
    send_frame(8'hC1, 0); send_frame(8'h40, 0);
    check_val("basic_vld_cnt", n_vld, 1);
    check_val("basic_vld_cyc", last_vld, n + 160 + 155);
    idle(560);
    check_val("basic_ch1_low", lows(1, cyc - 256), 64);
    check_val("basic_ch0_low", lows(0, cyc - 256), 0);
    check_val("basic_ch2_low", lows(2, cyc - 256), 0);

    send_frame(8'hC0, 0); send_frame(8'hFF, 0);
    idle(560);
    check_val("full_ch0_low", lows(0, cyc - 256), 255);
    send_frame(8'hC0, 0); send_frame(8'h00, 0);
    idle(560);
    check_val("zero_ch0_low", lows(0, cyc - 256), 0);
    check_val("extreme_vld_cnt", n_vld, 3);

    e0 = n_err;
    n = cyc;
    send_frame(8'hC5, 0); send_frame(8'h10, 0);
    check_val("badch_err_cnt", n_err - e0, 1);
    check_val("badch_err_cyc", last_err, n + 160 + 155);
    check_val("badch_vld_cnt", n_vld, 3);
    idle(560);
    check_val("badch_ch1_low", lows(1, cyc - 256), 64);
    check_val("badch_ch2_low", lows(2, cyc - 256), 0);

    n = cyc;
    send_frame(8'hC2, 0);
    idle(600);
    check_val("timeout_err_cnt", n_err - e0, 2);
    check_val("timeout_err_cyc", last_err, n + 155 + 400);
    check_val("timeout_vld_cnt", n_vld, 3);

    n = cyc;
    send_frame(8'hC0, 40);
    idle(20);
    check_val("frame_err_cnt", n_ferr, 1);
    check_val("frame_err_cyc", last_ferr, n + 155);
    check_val("frame_no_cmd", n_vld + n_err - e0, 5);

    s = n_vld + n_err + n_ferr;
    rx = 1'b0; idle(4); rx = 1'b1;
    idle(200);
    check_val("glitch_no_pulse", n_vld + n_err + n_ferr, s);

    n = cyc;
    send_frame(8'hC2, 0); send_frame(8'h80, 0);
    check_val("after_glitch_vld", n_vld, 4);
    check_val("after_glitch_cyc", last_vld, n + 160 + 155);
    idle(560);
    check_val("ch2_half_low", lows(2, cyc - 256), 128);

    // Land the channel-0 shadow write exactly on a PWM wrap edge.
    w = cyc + 330;
    while ((w - r0) % 255 != 0) w++;
    tick_to(w - 155 - 160);
    send_frame(8'hC0, 0); send_frame(8'h20, 0);
    check_val("wrap_vld_cyc", last_vld, w);
    tick_to(w + 512);
    check_val("wrap_old_period", lows(0, w + 1), 0);
    check_val("wrap_new_period", lows(0, w + 256), 32);

    s = n_vld + n_err + n_ferr;
    send_frame(8'hC1, 0);
    fork
      send_frame(8'h7F, 0);
      begin idle(70); rst_n = 1'b0; end
    join
    check_val("midrst_pwm", int'(pwm_out), 7);
    check_val("midrst_pulses", int'({cmd_valid, cmd_err, frame_err}), 0);
    rst_n = 1'b1;
    idle(300);
    check_val("midrst_no_cmd", n_vld + n_err + n_ferr, s);
    check_val("midrst_ch1_low", lows(1, cyc - 256), 0);
    check_val("midrst_ch2_low", lows(2, cyc - 256), 0);
    check_val("vld_err_overlap", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_pwm_rgb.md
# uart_pwm_rgb

Parametrised UART-to-PWM LED controller, the successor to the fixed three-LED byte-latch top level. It integrates an oversampling baud tick generator, a UART receiver with glitch rejection and framing-error detection, a two-byte command parser, and CHANNELS independent glitch-free PWM generators. It sits directly between the board `rx` pin and the RGB/LED driver pins.

## Interface
- CLOCK_FREQ, 12000000, system clock frequency in Hz
- BAUD, 9600, UART bit rate
- OVERSAMPLE, 16, ticks per bit; must be even and ≥4
- CHANNELS, 3, number of PWM outputs (1..16)
- PWM_BITS, 8, duty and counter width
- TIMEOUT_CYCLES, 24000, clocks allowed between address byte and duty byte
- ACTIVE_LOW, 1, 1 = outputs drive 0 when lit
- clk  in  1  system clock; all logic is on its rising edge
- rst_n  in  1  synchronous, active-low reset
- rx  in  1  asynchronous UART line, idle high
- pwm_out  out  CHANNELS  per-channel PWM; bit i is channel i
- cmd_valid  out  1  one-cycle pulse when a duty command is accepted
- cmd_err  out  1  one-cycle pulse on a bad channel or a timeout
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low

## Operation
- **Sync:** `rx` passes through a 2-flop synchroniser. Both flops reset to 1.
- **Tick:** DIV = CLOCK_FREQ/(BAUD*OVERSAMPLE), integer floor, minimum 1. The counter runs 0..DIV-1 and emits a one-cycle tick on wrap.
- **Receiver FSM:** IDLE → START → DATA → STOP, with a BREAK recovery state.
  - IDLE: a low synchronised `rx` sampled on a tick enters START.
  - START: after OVERSAMPLE/2 ticks, resample. Low goes to DATA; high is a glitch and returns to IDLE.
  - DATA: 8 samples taken OVERSAMPLE ticks apart, LSB first.
  - STOP: sample after OVERSAMPLE more ticks. High pulses internal byte_valid and returns to IDLE. Low pulses frame_err, discards the byte, and enters BREAK.
  - BREAK: wait until `rx` is sampled high, then go to IDLE.
- **Parser FSM:** P_IDLE and P_DUTY.
  - P_IDLE: a byte with [7:4]=4'hC is an address. Latch ch=[3:0], clear the timeout counter, and go to P_DUTY. All other bytes are ignored.
  - P_DUTY: the next byte is the duty. If ch<CHANNELS, write shadow[ch] = byte[PWM_BITS-1:0] and pulse cmd_valid. Otherwise pulse cmd_err and leave all shadows unchanged. Either way, return to P_IDLE.
  - P_DUTY timeout: the counter increments every clock. Reaching TIMEOUT_CYCLES pulses cmd_err and returns to P_IDLE.
  - P_DUTY frame_err: abandon the command and return to P_IDLE; cmd_err is not pulsed.
  - When PWM_BITS>8, the duty byte is zero-extended. When PWM_BITS<8, the upper bits are dropped.
- **PWM:**
  - One shared counter runs 0..2^PWM_BITS-2, a period of 2^PWM_BITS-1 clocks.
  - lit_i = (cnt < active[i]). Duty 0 is never lit; duty all-ones is always lit.
  - pwm_out[i] = lit_i XOR ACTIVE_LOW, registered.
  - active[i] ← shadow[i] only on the edge where cnt wraps from max to 0. A shadow write on that same edge takes effect the following period.

## Timing
- **Reset values** (rst_n sampled low on an edge):
  - pwm_out = all ACTIVE_LOW.
  - cmd_valid = cmd_err = frame_err = 0.
  - shadow = active = 0.
  - cnt, tick counter, and timeout counter = 0.
  - Both FSMs go to their idle states.
- **Reset mid-byte or mid-command:** the partial byte or command is dropped with no pulse. A byte already in flight on `rx` may be received as garbage after release.
- **Latencies:**
  - Line edge to receiver: 2-clock synchroniser latency.
  - byte_valid asserts at the stop-bit sample, (9.5*OVERSAMPLE) ticks after the start edge is detected.
  - cmd_valid asserts the cycle after byte_valid of the duty byte; shadow is updated on that same edge.
  - pwm_out reflects a new active value one clock after the wrap edge.
- **Pulse outputs:** each is exactly one cycle wide. cmd_valid and cmd_err are never high together.
- **Back-to-back frames** (stop bit immediately followed by a start bit) are received without loss.

## Test plan
Bench parameters: CLOCK_FREQ=1600000, BAUD=100000, OVERSAMPLE=16 (so DIV=1 and a bit is 16 clocks), PWM_BITS=8, TIMEOUT_CYCLES=400.

- **Reset:** hold rst_n low for 5 clocks, then release → pwm_out=3'b111, all pulses 0, and no pulse for 300 idle clocks.
- **Basic command:** send 0xC1 then 0x40 → cmd_valid once, one clock after the second stop sample. From the next wrap, pwm_out[1] is low for 64 of every 255 clocks; channels 0 and 2 stay high.
- **Extremes:** send 0xC0,0xFF → pwm_out[0] constantly 0. Then send 0xC0,0x00 → constantly 1, with no 1-clock glitch at the wrap.
- **Bad channel and timeout:** send 0xC5,0x10 → cmd_err once, no duty change. Send 0xC2 followed by silence → cmd_err exactly 400 clocks after the address byte, parser back in P_IDLE.
- **Framing and glitch:** send 0xC0 with its stop bit held low for 40 clocks → frame_err once, no cmd_valid. A 4-clock low glitch on idle `rx` → no byte and no pulses. The following valid pair 0xC2,0x80 → accepted.
- **Shadow and reset:** write channel 0 on the wrap edge → the new duty appears one period later. Assert rst_n mid-duty-byte → all outputs return to their reset values and the partial command is discarded.
